// File: rtl/req_arbiter8_if.sv
// Request/grant bundle between eight requesters and the shared-resource arbiter.
interface req_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] mask;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic [2:0] timeout_id;

  modport master (
    output en, req, mask, done,
    input  gnt, gnt_id, gnt_valid, timeout, timeout_id
  );

  modport slave (
    input  en, req, mask, done,
    output gnt, gnt_id, gnt_valid, timeout, timeout_id
  );
endinterface

// File: rtl/req_arbiter8.sv
// Eight-way arbiter: picks one eligible requester in IDLE (fixed priority or
// round robin), holds the grant until done or a hold timeout force-releases it.
module req_arbiter8 #(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic         clk,
  input logic         rst,
  req_arbiter8_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] last_q, last_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gid_q, gid_d;
  logic       gv_q, gv_d;
  logic       tmo_q, tmo_d;
  logic [2:0] tid_q, tid_d;

  logic [7:0] elig;
  logic [2:0] win_id;
  logic       win_found;
  logic [2:0] scan_idx;

  assign elig = bus.req & ~bus.mask;

  // Winner selection: MSB-first priority encode, or first set bit after last.
  always_comb begin
    win_id    = 3'd0;
    win_found = 1'b0;
    scan_idx  = 3'd0;
    if (RR_EN) begin
      // k=8 wraps to last itself, so the previous owner is considered last.
      for (int k = 1; k <= 8; k++) begin
        scan_idx = last_q + 3'(k);
        if (!win_found && elig[scan_idx]) begin
          win_id    = scan_idx;
          win_found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (elig[i]) begin
          win_id    = 3'(i);
          win_found = 1'b1;
        end
      end
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    gid_d   = gid_q;
    gv_d    = gv_q;
    tmo_d   = 1'b0;
    tid_d   = tid_q;
    case (state_q)
      IDLE: begin
        if (bus.en && win_found) begin
          gnt_d   = 8'b1 << win_id;
          gid_d   = win_id;
          gv_d    = 1'b1;
          hcnt_d  = 8'd0;
          state_d = BUSY;
          if (RR_EN) last_d = win_id;
        end
      end
      BUSY: begin
        hcnt_d = hcnt_q + 8'd1;
        // done is checked first so a release on the final cycle is not a timeout.
        if (bus.done) begin
          gnt_d   = 8'd0;
          gid_d   = 3'd0;
          gv_d    = 1'b0;
          state_d = IDLE;
        end else if (hcnt_q == HOLD_LAST) begin
          gnt_d   = 8'd0;
          gid_d   = 3'd0;
          gv_d    = 1'b0;
          tmo_d   = 1'b1;
          tid_d   = gid_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= 8'd0;
      last_q  <= 3'd7;
      gnt_q   <= 8'd0;
      gid_q   <= 3'd0;
      gv_q    <= 1'b0;
      tmo_q   <= 1'b0;
      tid_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      gid_q   <= gid_d;
      gv_q    <= gv_d;
      tmo_q   <= tmo_d;
      tid_q   <= tid_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.gnt_id     = gid_q;
  assign bus.gnt_valid  = gv_q;
  assign bus.timeout    = tmo_q;
  assign bus.timeout_id = tid_q;

endmodule
